// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Arbitrates an instruction-fetch port and a load/store port |
// |               onto one shared single-outstanding memory port. IDLE       |
// |               grants one request, FETCH/DATA wait for mem_ready, then    |
// |               a one-cycle ready pulse returns registered read data.      |
// |               A flush during a fetch lets the memory cycle finish but    |
// |               suppresses its if_ready pulse and if_rdata update.         |
// | Config      : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests   |
// |               alternate between ports; otherwise data always wins.       |
// | Ports       : clk, rst (async, active-high)                              |
// |               if_req/if_addr -> if_ready/if_rdata   fetch port           |
// |               dm_req/dm_we/dm_addr/dm_wdata -> dm_ready/dm_rdata  data   |
// |               flush                       cancels the in-flight fetch    |
// |               mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_if_ready;
    logic [31:0]         r_if_rdata;
    logic                r_dm_ready;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_drop;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_grant_dm;
    logic w_grant_if;
    logic w_drop_now;

    // A completion cycle is a turnaround cycle: no new grant is made while
    // either ready pulse is high. This keeps a held request from being
    // granted twice, and lets a held data request compete against a waiting
    // fetch on equal footing in the following cycle.
    assign w_if_elig = if_req & ~r_if_ready & ~r_dm_ready;
    assign w_dm_elig = dm_req & ~r_dm_ready & ~r_if_ready;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data port was granted most recently, 0 = fetch port.
    logic r_last_dm;

    assign w_grant_dm = w_dm_elig & (~w_if_elig | ~r_last_dm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_dm <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_grant_dm) begin
                r_last_dm <= 1'b1;
            end else if (w_if_elig) begin
                r_last_dm <= 1'b0;
            end
        end
    end
`else
    // Data op belongs to an older instruction, so it always wins.
    assign w_grant_dm = w_dm_elig;
`endif

    assign w_grant_if = w_if_elig & ~w_grant_dm;

    // A flush in the completing cycle itself also cancels the fetch.
    assign w_drop_now = r_drop | flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_ready  <= 1'b0;
            r_dm_rdata  <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_dm) begin
                        r_mem_addr  <= dm_addr;
                        r_mem_we    <= dm_we;
                        r_mem_wdata <= dm_wdata;
                        r_mem_req   <= 1'b1;
                        r_state     <= DATA;
                    end else if (w_grant_if) begin
                        r_mem_addr <= if_addr;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        if (!w_drop_now) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= r_mem_addr[2] ? mem_rdata[63:32]
                                                        : mem_rdata[31:0];
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        r_state    <= IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_dm_ready <= 1'b1;
                        r_dm_rdata <= mem_rdata;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_ready  = r_dm_ready;
    assign dm_rdata  = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Self-checking bench for mem_port_arbiter. A memory model   |
// |               pops expected transactions at grant time and queues the    |
// |               expected ready results; a monitor pops them on each ready  |
// |               pulse. Build with ARB_ROUND_ROBIN_EN to test that variant. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] mem_rd;
        int          lat;
        logic [63:0] exp_out;
        bit          drop;
    } txn_t;

    typedef struct {
        bit          is_data;
        logic [63:0] exp_out;
    } rdy_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ready;
    logic [63:0] dm_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    txn_t        exp_q[$];
    rdy_t        rdy_q[$];
    int          errors = 0;
    int          checks = 0;
    int          grants = 0;
    int          stray_req = 0;
    logic [31:0] last_if = '0;
    logic [63:0] last_dm = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ready (dm_ready),
        .dm_rdata (dm_rdata),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected result model: fetch returns the 32-bit half selected by addr[2].
    function automatic txn_t mk(input bit d, input bit w, input logic [31:0] a,
                                input logic [63:0] wd, input logic [63:0] rd,
                                input int lat, input bit drop);
        txn_t t;
        t.is_data = d;
        t.we      = w;
        t.addr    = a;
        t.wdata   = wd;
        t.mem_rd  = rd;
        t.lat     = lat;
        t.drop    = drop;
        if (d)         t.exp_out = rd;
        else if (a[2]) t.exp_out = {32'h0, rd[63:32]};
        else           t.exp_out = {32'h0, rd[31:0]};
        return t;
    endfunction

    // Memory model: checks each grant against the scoreboard, checks the
    // request stays stable, and answers after the transaction's latency.
    initial begin : b_mem
        txn_t cur;
        int   cnt;
        bit   busy;
        int   stray_seen;
        mem_ready = 1'b0;
        mem_rdata = '0;
        busy = 1'b0;
        cnt = 0;
        stray_seen = 0;
        cur = mk(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1, 1'b1);
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst) begin
                busy = 1'b0;
                cnt = 0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    grants++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", {63'h0, mem_req}, 64'h0);
                        cur = mk(1'b0, mem_we, mem_addr, mem_wdata, 64'h0, 1, 1'b1);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    chk("grant_addr", {32'h0, mem_addr}, {32'h0, cur.addr});
                    chk("grant_we", {63'h0, mem_we}, {63'h0, cur.we});
                    if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
                end else begin
                    chk("hold_addr", {32'h0, mem_addr}, {32'h0, cur.addr});
                    chk("hold_we", {63'h0, mem_we}, {63'h0, cur.we});
                    if (cur.we) chk("hold_wdata", mem_wdata, cur.wdata);
                end
                cnt++;
                if (cnt >= cur.lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.mem_rd;
                    if (!cur.drop) rdy_q.push_back('{cur.is_data, cur.exp_out});
                end
            end else begin
                busy = 1'b0;
                if (stray_req != stray_seen) begin
                    stray_seen = stray_req;
                    mem_ready = 1'b1;
                    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end
        end
    end

    // Ready monitor: every pulse must match the next queued completion.
    initial begin : b_mon
        rdy_t r;
        forever begin
            @(negedge clk);
            if (!rst && (if_ready || dm_ready)) begin
                if (rdy_q.size() == 0) begin
                    chk("unexpected_ready", {62'h0, if_ready, dm_ready}, 64'h0);
                end else begin
                    r = rdy_q.pop_front();
                    chk("ready_dm", {63'h0, dm_ready}, {63'h0, r.is_data});
                    chk("ready_if", {63'h0, if_ready}, {63'h0, ~r.is_data});
                    if (r.is_data) chk("dm_rdata", dm_rdata, r.exp_out);
                    else           chk("if_rdata", {32'h0, if_rdata}, r.exp_out);
                end
            end
        end
    end

    initial begin : b_watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input bit is_data, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (is_data ? dm_ready : if_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", {63'h0, is_data ? dm_ready : if_ready}, 64'h1);
    endtask

    task automatic run_txn(input txn_t t);
        int n;
        bit ok;
        exp_q.push_back(t);
        if (t.is_data) begin
            dm_req = 1'b1;
            dm_we = t.we;
            dm_addr = t.addr;
            dm_wdata = t.wdata;
        end else begin
            if_req = 1'b1;
            if_addr = t.addr;
        end
        wait_ready(t.is_data, n, ok);
        if (ok) chk("latency", 64'(n), 64'(t.lat + 1));
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        if (t.is_data) last_dm = t.exp_out;
        else           last_if = t.exp_out[31:0];
        @(negedge clk);
        chk("if_rdata_hold", {32'h0, if_rdata}, {32'h0, last_if});
        chk("dm_rdata_hold", dm_rdata, last_dm);
    endtask

    initial begin : b_main
        txn_t vec[6];
        txn_t t;
        int   pulses;
        int   g0;
        bit   ok;
        int   n;

        vec[0] = mk(1'b0, 1'b0, 32'h104, 64'h0, 64'hAAAA5555_12345678, 1, 1'b0);
        vec[1] = mk(1'b1, 1'b1, 32'h200, 64'h01234567_89ABCDEF, 64'h11112222_33334444, 3, 1'b0);
        vec[2] = mk(1'b0, 1'b0, 32'h108, 64'h0, 64'hCAFEBABE_DEADBEEF, 2, 1'b0);
        vec[3] = mk(1'b1, 1'b0, 32'h300, 64'h0, 64'h5A5A5A5A_A5A5A5A5, 1, 1'b0);
        vec[4] = mk(1'b1, 1'b0, 32'h308, 64'h0, 64'h13579BDF_2468ACE0, 2, 1'b0);
        vec[5] = mk(1'b0, 1'b0, 32'h10C, 64'h0, 64'h87654321_0F0F0F0F, 4, 1'b0);

        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
        chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_ready", {62'h0, if_ready, dm_ready}, 64'h0);
        chk("rst_if_rdata", {32'h0, if_rdata}, 64'h0);
        chk("rst_dm_rdata", dm_rdata, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single transactions with varied latency, direction and addr[2].
        for (int i = 0; i < 6; i++) run_txn(vec[i]);

        // Simultaneous held requests: four grants.
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 64'h0, 64'h00000000_00000D01, 1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h500, 64'h0, 64'h00000000_00000F02, 1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 64'h0, 64'h00000000_00000D03, 1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h500, 64'h0, 64'h00000000_00000F04, 1, 1'b0));
        last_if = 32'h0000_0F04;
        last_dm = 64'h0000_0D03;
`else
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 64'h0, 64'h00000000_00000D01, 1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 64'h0, 64'h00000000_00000D02, 1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 64'h0, 64'h00000000_00000D03, 1, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 64'h0, 64'h00000000_00000D04, 1, 1'b0));
        last_dm = 64'h0000_0D04;
`endif
        g0 = grants;
        pulses = 0;
        if_req = 1'b1;
        if_addr = 32'h500;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h600;
        for (int i = 0; i < 100 && pulses < 4; i++) begin
            @(negedge clk);
            if (if_ready || dm_ready) pulses++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        chk("order_pulses", 64'(pulses), 64'd4);
        chk("order_grants", 64'(grants - g0), 64'd4);
        chk("order_if_rdata", {32'h0, if_rdata}, {32'h0, last_if});

        // Flush one cycle after a fetch grant: memory completes, no if_ready.
        exp_q.push_back(mk(1'b0, 1'b0, 32'h40, 64'h0, 64'h99999999_88888888, 3, 1'b1));
        if_req = 1'b1;
        if_addr = 32'h40;
        @(negedge clk);
        flush = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("flush_mem_timeout", {63'h0, mem_req}, 64'h0);
        @(negedge clk);
        chk("flush_no_ready", {63'h0, if_ready}, 64'h0);
        chk("flush_if_rdata", {32'h0, if_rdata}, {32'h0, last_if});
        run_txn(mk(1'b0, 1'b0, 32'h80, 64'h0, 64'h77777777_66666666, 1, 1'b0));

        // Flush held across a data transaction has no effect.
        flush = 1'b1;
        run_txn(mk(1'b1, 1'b0, 32'h408, 64'h0, 64'hFEDCBA98_76543210, 2, 1'b0));
        flush = 1'b0;

        // Stray mem_ready in IDLE is ignored.
        stray_req++;
        repeat (3) @(negedge clk);
        chk("stray_mem_req", {63'h0, mem_req}, 64'h0);
        chk("stray_dm_rdata", dm_rdata, last_dm);

        // Fetch held through its ready cycle: exactly one grant.
        g0 = grants;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h1C4, 64'h0, 64'h0BADF00D_12121212, 1, 1'b0));
        if_req = 1'b1;
        if_addr = 32'h1C4;
        wait_ready(1'b0, n, ok);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        last_if = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        chk("hold_one_grant", 64'(grants - g0), 64'd1);
        chk("hold_mem_req", {63'h0, mem_req}, 64'h0);

        // Reset in the middle of a data transaction.
        exp_q.push_back(mk(1'b1, 1'b1, 32'h700, 64'h55AA55AA_55AA55AA, 64'h0, 6, 1'b1));
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h700;
        dm_wdata = 64'h55AA55AA_55AA55AA;
        repeat (2) @(negedge clk);
        chk("abort_pre_req", {63'h0, mem_req}, 64'h1);
        rst = 1'b1;
        dm_req = 1'b0;
        dm_we = 1'b0;
        #1;
        chk("abort_mem_req", {63'h0, mem_req}, 64'h0);
        chk("abort_mem_we", {63'h0, mem_we}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_ready", {62'h0, if_ready, dm_ready}, 64'h0);
        chk("abort_dm_rdata", dm_rdata, 64'h0);
        chk("abort_if_rdata", {32'h0, if_rdata}, 64'h0);
        last_if = '0;
        last_dm = '0;
        run_txn(mk(1'b1, 1'b0, 32'h710, 64'h0, 64'h31415926_53589793, 1, 1'b0));

        repeat (2) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("rdy_q_empty", 64'(rdy_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 64, memory data width.
REQ-002 SHALL have ports, one per line, as below; reset rst, asynchronous, active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address, word-aligned
- if_ready  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched instruction
- dm_req  in  1  load/store request; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ready  out  1  one-cycle data completion pulse
- dm_rdata  out  DATA_W  load data
- flush  in  1  pipeline redirect (mispredict); cancels the in-flight fetch
- mem_req  out  1  shared memory request, level
- mem_we  out  1  shared memory write enable
- mem_addr  out  ADDR_W  shared memory address
- mem_wdata  out  DATA_W  shared memory write data
- mem_rdata  in  DATA_W  shared memory read data, valid with mem_ready
- mem_ready  in  1  shared memory completion, single-cycle pulse

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, DATA; only one transaction is outstanding at a time.
REQ-004 IDLE: at the clock edge where an eligible request is sampled, SHALL latch the address (plus we/wdata for data), move to FETCH or DATA and drive mem_req=1 from the next cycle.
REQ-005 mem_addr, mem_we and mem_wdata SHALL come from the latched registers and stay stable while mem_req=1; mem_we SHALL be 0 in FETCH.
REQ-006 FETCH/DATA: when mem_ready is sampled high, the FSM SHALL return to IDLE and drop mem_req, and the matching ready SHALL be high for exactly the next cycle.
REQ-007 Completion SHALL register the read data: if_rdata = mem_rdata[31:0] when latched addr[2]=0, else mem_rdata[63:32]; dm_rdata = mem_rdata; data outputs hold until the next completion.
REQ-008 Minimum latency: request sampled at edge k, mem_ready at edge k+1, ready high in cycle k+1..k+2, i.e. 2 cycles.
REQ-009 In IDLE, a port's req SHALL be ignored in the cycle its own ready is high, so a held request is not granted twice.
REQ-010 Default priority: when if_req and dm_req are both eligible in IDLE, data SHALL win, because the data op belongs to an older instruction.
REQ-011 flush high in any cycle while in FETCH SHALL set a drop flag; the memory transaction still completes, but if_ready SHALL NOT pulse and if_rdata SHALL NOT update. The flag SHALL clear on return to IDLE.
REQ-012 flush SHALL NOT affect DATA transactions, an IDLE state or an if_ready pulse already high.
REQ-013 mem_ready in IDLE SHALL be ignored.

Reset
REQ-014 While rst=1: state=IDLE; mem_req, mem_we, if_ready, dm_ready, drop flag = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; round-robin pointer = "fetch last granted".
REQ-015 Reset mid-transaction SHALL abort the transaction immediately, with no ready pulse afterwards; the requester re-issues after reset.

Configuration
REQ-016 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted to the port not granted most recently, and the pointer updates on every grant. When undefined, fixed data-over-fetch priority (REQ-010) applies and no pointer exists.

Verification
REQ-017 Single fetch: if_req=1, if_addr=0x104, mem_ready one cycle after mem_req, mem_rdata=0xAAAA5555_12345678 -> mem_addr=0x104, mem_we=0, if_ready one cycle, if_rdata=0xAAAA5555.
REQ-018 Store: dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0x0123456789ABCDEF, mem_ready after 3 cycles -> mem_we=1 and address/data stable for 3 cycles, dm_ready one cycle, if_ready stays 0.
REQ-019 Simultaneous if_req and dm_req, both held for 4 grants, macro undefined -> grant order D,D,D,D while dm_req is held; with ARB_ROUND_ROBIN_EN -> D,F,D,F.
REQ-020 flush pulse 1 cycle after a fetch grant to 0x40 -> mem transaction completes, no if_ready pulse; the next fetch to 0x80 completes normally.
REQ-021 rst asserted while in DATA with mem_req=1 -> mem_req=0 in the same cycle, no dm_ready pulse, state IDLE after release.
REQ-022 Requester holds if_req through its if_ready cycle -> exactly one mem transaction per if_ready pulse, with no duplicate grant.
